// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Purpose  : Fetch/execute micro-state sequencer for the 8-bit accumulator
//            CPU. It walks FETCH1..FETCH3 and then the execute states of the
//            fetched instruction. It also latches the opcode and flags
//            illegal opcodes. The downstream combinational control decoder
//            derives every register, ALU and memory strobe from STATE and
//            OPCODE.
// Ports    : CLK      in   system clock, rising-edge active
//            CLEAR    in   synchronous active-low reset
//            DR[7:0]  in   data register (instruction byte during FETCH3)
//            Z        in   zero flag, sampled only on the FETCH3 edge
//            MEM_RDY  in   memory ready (wait-state build only)
//            STATE    out  current micro-state code (6 bits)
//            OPCODE   out  opcode latched on the FETCH3 edge
//            ILLEGAL  out  last fetched byte was not a legal opcode
//            LAST     out  final state of the current instruction
//            MEM_REQ  out  current state reads or writes memory
// Options  : define CTRL_MEMWAIT_EN to stall MEM_REQ states until MEM_RDY=1
// Revision : 1.0 - initial release
// ============================================================================
module control_sequencer (
  input  logic       CLK,
  input  logic       CLEAR,
  input  logic [7:0] DR,
  input  logic       Z,
  input  logic       MEM_RDY,
  output logic [5:0] STATE,
  output logic [3:0] OPCODE,
  output logic       ILLEGAL,
  output logic       LAST,
  output logic       MEM_REQ
);

  typedef enum logic [5:0] {
    S_FETCH1 = 6'd0,  S_FETCH2 = 6'd1,  S_FETCH3 = 6'd2,
    S_NOP1   = 6'd3,
    S_LDAC1  = 6'd4,  S_LDAC2  = 6'd5,  S_LDAC3  = 6'd6,
    S_LDAC4  = 6'd7,  S_LDAC5  = 6'd8,
    S_STAC1  = 6'd9,  S_STAC2  = 6'd10, S_STAC3  = 6'd11,
    S_STAC4  = 6'd12, S_STAC5  = 6'd13,
    S_MVAC1  = 6'd14, S_MOVR1  = 6'd15,
    S_JUMP1  = 6'd16, S_JUMP2  = 6'd17, S_JUMP3  = 6'd18,
    S_JMPZY1 = 6'd19, S_JMPZY2 = 6'd20, S_JMPZY3 = 6'd21,
    S_JMPZN1 = 6'd22, S_JMPZN2 = 6'd23,
    S_JPNZY1 = 6'd24, S_JPNZY2 = 6'd25, S_JPNZY3 = 6'd26,
    S_JPNZN1 = 6'd27, S_JPNZN2 = 6'd28,
    S_ADD1   = 6'd29, S_SUB1   = 6'd30, S_INAC1  = 6'd31, S_CLAC1  = 6'd32,
    S_AND1   = 6'd33, S_OR1    = 6'd34, S_XOR1   = 6'd35, S_NOT1   = 6'd36
  } state_t;

  localparam logic [3:0] C_OP_JMPZ = 4'h6;
  localparam logic [3:0] C_OP_JPNZ = 4'h7;

  state_t     r_state;
  state_t     w_next_state;
  state_t     w_fetch3_target;
  logic [3:0] r_opcode;
  logic       r_illegal;
  logic       w_dr_legal;
  logic       w_last;
  logic       w_mem_req;
  logic       w_advance;

  // Only bytes with a zero upper nibble are instructions.
  assign w_dr_legal = (DR[7:4] == 4'h0);

  // Exit from FETCH3. Z is looked at here only, so later changes of Z
  // cannot redirect a branch that is already under way.
  always_comb begin
    w_fetch3_target = S_NOP1;
    if (w_dr_legal) begin
      case (DR[3:0])
        4'h0:      w_fetch3_target = S_NOP1;
        4'h1:      w_fetch3_target = S_LDAC1;
        4'h2:      w_fetch3_target = S_STAC1;
        4'h3:      w_fetch3_target = S_MVAC1;
        4'h4:      w_fetch3_target = S_MOVR1;
        4'h5:      w_fetch3_target = S_JUMP1;
        C_OP_JMPZ: w_fetch3_target = Z ? S_JMPZY1 : S_JMPZN1;
        C_OP_JPNZ: w_fetch3_target = Z ? S_JPNZN1 : S_JPNZY1;
        4'h8:      w_fetch3_target = S_ADD1;
        4'h9:      w_fetch3_target = S_SUB1;
        4'hA:      w_fetch3_target = S_INAC1;
        4'hB:      w_fetch3_target = S_CLAC1;
        4'hC:      w_fetch3_target = S_AND1;
        4'hD:      w_fetch3_target = S_OR1;
        4'hE:      w_fetch3_target = S_XOR1;
        4'hF:      w_fetch3_target = S_NOT1;
        default:   w_fetch3_target = S_NOP1;
      endcase
    end
  end

  // Next-state logic. Every final state and every unreachable code falls
  // through to the default, which returns to FETCH1.
  always_comb begin
    w_next_state = S_FETCH1;
    case (r_state)
      S_FETCH1: w_next_state = S_FETCH2;
      S_FETCH2: w_next_state = S_FETCH3;
      S_FETCH3: w_next_state = w_fetch3_target;
      S_LDAC1:  w_next_state = S_LDAC2;
      S_LDAC2:  w_next_state = S_LDAC3;
      S_LDAC3:  w_next_state = S_LDAC4;
      S_LDAC4:  w_next_state = S_LDAC5;
      S_STAC1:  w_next_state = S_STAC2;
      S_STAC2:  w_next_state = S_STAC3;
      S_STAC3:  w_next_state = S_STAC4;
      S_STAC4:  w_next_state = S_STAC5;
      S_JUMP1:  w_next_state = S_JUMP2;
      S_JUMP2:  w_next_state = S_JUMP3;
      S_JMPZY1: w_next_state = S_JMPZY2;
      S_JMPZY2: w_next_state = S_JMPZY3;
      S_JMPZN1: w_next_state = S_JMPZN2;
      S_JPNZY1: w_next_state = S_JPNZY2;
      S_JPNZY2: w_next_state = S_JPNZY3;
      S_JPNZN1: w_next_state = S_JPNZN2;
      default:  w_next_state = S_FETCH1;
    endcase
  end

  // Final-state decode.
  always_comb begin
    w_last = 1'b0;
    case (r_state)
      S_NOP1, S_LDAC5, S_STAC5, S_MVAC1, S_MOVR1,
      S_JUMP3, S_JMPZY3, S_JMPZN2, S_JPNZY3, S_JPNZN2,
      S_ADD1, S_SUB1, S_INAC1, S_CLAC1,
      S_AND1, S_OR1, S_XOR1, S_NOT1: w_last = 1'b1;
      default:                       w_last = 1'b0;
    endcase
  end

  // Memory-access state decode.
  always_comb begin
    w_mem_req = 1'b0;
    case (r_state)
      S_FETCH2,
      S_LDAC1, S_LDAC2, S_LDAC4,
      S_STAC1, S_STAC2, S_STAC5,
      S_JUMP1, S_JUMP2,
      S_JMPZY1, S_JMPZY2,
      S_JPNZY1, S_JPNZY2: w_mem_req = 1'b1;
      default:            w_mem_req = 1'b0;
    endcase
  end

`ifdef CTRL_MEMWAIT_EN
  // A memory state only moves on once the memory signals ready.
  assign w_advance = ~w_mem_req | MEM_RDY;
`else
  logic w_unused_mem_rdy;
  assign w_unused_mem_rdy = MEM_RDY;
  assign w_advance        = 1'b1;
`endif

  // State, opcode and illegal flag. Reset overrides any stall.
  always_ff @(posedge CLK) begin
    if (!CLEAR) begin
      r_state   <= S_FETCH1;
      r_opcode  <= 4'h0;
      r_illegal <= 1'b0;
    end else if (w_advance) begin
      r_state <= w_next_state;
      if (r_state == S_FETCH3) begin
        r_opcode  <= w_dr_legal ? DR[3:0] : 4'h0;
        r_illegal <= ~w_dr_legal;
      end
    end
  end

  assign STATE   = r_state;
  assign OPCODE  = r_opcode;
  assign ILLEGAL = r_illegal;
  assign LAST    = w_last;
  assign MEM_REQ = w_mem_req;

endmodule
`default_nettype wire
